mulby255_seq: RTL and testbench
===============================

Name: mulby255_seq

Overview:
- Sequential multiply-by-255 unit; the inverse of the team's divide-by-255 datapath.
- Takes a 32-bit operand as two 16-bit halves on a shared bus and forms A*255 by 8 shift-add cycles.
- Returns the low 32 bits of the product as two 16-bit halves on a registered output bus, plus an overflow flag.
- Used to regenerate and check dividends from quotients produced by the divider.

Parameters:
- W, 16, half-word width; operand and result are 2*W bits. Only W=16 is verified.
- NSTEP, 8, number of shift-add steps. Equals the count of ones in the constant 255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- x  input  16  shared operand half-word bus
- ld_msb  input  1  load x into A[31:16]
- ld_lsb  input  1  load x into A[15:0]
- start  input  1  begin multiplication of the held A
- rd_msb  input  1  drive result[31:16] onto y
- rd_lsb  input  1  drive result[15:0] onto y
- y  output  16  registered result half-word
- busy  output  1  high while computing
- done  output  1  result valid
- ovf  output  1  product bits [39:32] nonzero; valid when done=1

Behaviour:
- All actions are sampled on the rising edge of clk.
- Reset (rst=1 at an edge, in any state, including mid-RUN):
  - A, acc, cnt, y clear to 0.
  - busy=0, done=0, ovf=0.
  - State goes to IDLE; any in-flight computation is discarded.
- States: IDLE, RUN, DONE.
- Loads:
  - Accepted only in IDLE or DONE.
  - ld_msb writes A[31:16]=x; ld_lsb writes A[15:0]=x. Both high in the same cycle writes x to both halves.
  - Any accepted load in DONE returns the block to IDLE and clears done.
  - Loads during RUN are ignored.
- start:
  - Accepted in IDLE or DONE only when no load is asserted in the same cycle. A simultaneous load wins and start is dropped.
  - On acceptance: acc=0, cnt=0, state=RUN, busy=1, done=0.
  - start during RUN is ignored.
- RUN step, one per edge:
  - acc <= acc + (A << cnt), with acc 40 bits wide and no truncation.
  - cnt increments.
  - On the edge where cnt==7 before the update: state=DONE, busy=0, done=1, ovf=|acc_next[39:32].
- Latency:
  - start accepted at edge E0; busy is high after E0 through E7.
  - done is high after E8, i.e. 8 cycles of busy, with the result readable from the cycle after E8.
- done, ovf and the result hold until reset, the next accepted start, or a load.
- Reads:
  - Accepted only in DONE.
  - rd_msb: y <= acc[31:16]. rd_lsb: y <= acc[15:0]. Both high: rd_msb wins.
  - y updates one edge after the read is sampled.
  - With no read, or a read outside DONE, y holds its value.
- Arithmetic:
  - Result is A*255 mod 2^32.
  - Exact whenever A <= 0x01010101; ovf=0 in that range.
- A is not modified by computation; restarting without loads recomputes the same product.

Test Plan:
- Reset, then ld_msb with x=0x0000, ld_lsb with x=0x0064 (A=100), start -> busy high 8 cycles, then done=1, ovf=0. rd_msb -> y=0x0000; rd_lsb -> y=0x639C (25500).
- A=10, start -> done; rd_lsb -> y=0x09F6; rd_msb -> y=0x0000. Then with rd_msb and rd_lsb high together -> y=0x0000 (msb wins).
- A=0x01010101, start -> y_MSB=0xFFFF, y_LSB=0xFFFF, ovf=0. Then A=0xFFFFFFFF, start -> y_MSB=0xFFFF, y_LSB=0xFF01, ovf=1.
- During RUN, pulse ld_lsb with x=0x1234, pulse start, pulse rd_lsb -> all ignored: cycle count unchanged, result matches the original A, y unchanged until DONE.
- Assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, y=0, state IDLE. start with A=0 -> done after 8 cycles, y=0x0000 on both reads.
- In DONE, assert ld_lsb and start together -> done clears, no RUN entered (busy stays 0). A following start alone computes using the newly loaded half.

Source files
------------

// File: rtl/mulby255_seq.sv
// Sequential A*255 by shift-add, one step per clock.
// Operand loaded and result read as 16-bit halves over shared buses.
module mulby255_seq #(
    parameter int W     = 16,
    parameter int NSTEP = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic         ld_msb,
    input  logic         ld_lsb,
    input  logic         start,
    input  logic         rd_msb,
    input  logic         rd_lsb,
    output logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    localparam int AW = 2 * W;
    localparam int PW = AW + 8;
    localparam int CW = $clog2(NSTEP);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   a;
    logic [PW-1:0]   acc, acc_n;
    logic [CW-1:0]   cnt;
    logic            ld, open, go, last;

    assign ld    = ld_msb | ld_lsb;
    assign open  = (state != RUN);
    // a load in the same cycle takes priority over start
    assign go    = start & ~ld & open;
    assign last  = (cnt == LAST);
    assign acc_n = acc + ({8'b0, a} << cnt);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go) state_n = RUN;
            RUN:  if (last) state_n = DONE;
            DONE: begin
                if (ld)      state_n = IDLE;
                else if (go) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            acc   <= '0;
            cnt   <= '0;
            y     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (open && ld) begin
                if (ld_msb) a[AW-1:W] <= x;
                if (ld_lsb) a[W-1:0]  <= x;
                ovf <= 1'b0;
            end
            if (go) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
            if (state == RUN) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
                if (last) ovf <= |acc_n[PW-1:AW];
            end
            if (state == DONE) begin
                if (rd_msb)      y <= acc[AW-1:W];
                else if (rd_lsb) y <= acc[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mulby255_seq.sv
// Bench for mulby255_seq: scoreboard of expected products,
// popped and compared when each computation completes.
module tb_mulby255_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] x = '0;
    logic        ld_msb = 1'b0, ld_lsb = 1'b0, start = 1'b0;
    logic        rd_msb = 1'b0, rd_lsb = 1'b0;
    logic [15:0] y;
    logic        busy, done, ovf;

    logic [39:0] exp_q[$];
    logic [31:0] mdl_a;
    int total = 0;
    int bad   = 0;

    mulby255_seq dut (
        .clk(clk), .rst(rst), .x(x),
        .ld_msb(ld_msb), .ld_lsb(ld_lsb), .start(start),
        .rd_msb(rd_msb), .rd_lsb(rd_lsb),
        .y(y), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        x = v[31:16]; ld_msb = 1'b1; tick(); ld_msb = 1'b0;
        x = v[15:0];  ld_lsb = 1'b1; tick(); ld_lsb = 1'b0;
        mdl_a = v;
    endtask

    task automatic go(output int n);
        start = 1'b1;
        exp_q.push_back({8'b0, mdl_a} * 40'd255);
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic rd(input logic m, input logic l);
        rd_msb = m; rd_lsb = l; tick();
        rd_msb = 1'b0; rd_lsb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        mdl_a = '0;
        total++;
        if ({busy, done, ovf, y} !== 19'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b ovf=%b y=%h want 0",
                     busy, done, ovf, y);
        end
    endtask

    task automatic test_arith();
        logic [31:0] tbl[4];
        logic [39:0] e;
        int n;
        tbl[0] = 32'd100;
        tbl[1] = 32'd10;
        tbl[2] = 32'h01010101;
        tbl[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            load(tbl[i]);
            go(n);
            e = exp_q.pop_front();
            total++;
            if (n !== 8 || done !== 1'b1 || ovf !== (|e[39:32])) begin
                bad++;
                $display("FAIL arith%0d ctl: busy_cyc=%0d done=%b ovf=%b want 8 1 %b",
                         i, n, done, ovf, |e[39:32]);
            end
            rd(1'b1, 1'b0);
            total++;
            if (y !== e[31:16]) begin
                bad++;
                $display("FAIL arith%0d msb: y=%h want %h", i, y, e[31:16]);
            end
            rd(1'b0, 1'b1);
            total++;
            if (y !== e[15:0]) begin
                bad++;
                $display("FAIL arith%0d lsb: y=%h want %h", i, y, e[15:0]);
            end
            rd(1'b1, 1'b1);
            total++;
            if (y !== e[31:16]) begin
                bad++;
                $display("FAIL arith%0d both: y=%h want %h", i, y, e[31:16]);
            end
        end
    endtask

    task automatic test_run_ignore();
        logic [39:0] e;
        logic [15:0] y0;
        int n;
        load(32'h00020003);
        y0 = y;
        start = 1'b1;
        exp_q.push_back({8'b0, mdl_a} * 40'd255);
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy) n++;
            x = 16'h1234;
            ld_lsb = (i == 0);
            start  = (i == 1);
            rd_lsb = (i == 2);
            tick();
            ld_lsb = 1'b0; start = 1'b0; rd_lsb = 1'b0;
        end
        while (busy && n < 20) begin
            n++;
            tick();
        end
        e = exp_q.pop_front();
        total++;
        if (n !== 8 || done !== 1'b1 || y !== y0) begin
            bad++;
            $display("FAIL run_ignore: busy_cyc=%0d done=%b y=%h want 8 1 %h",
                     n, done, y, y0);
        end
        rd(1'b0, 1'b1);
        total++;
        if (y !== e[15:0]) begin
            bad++;
            $display("FAIL run_ignore lsb: y=%h want %h", y, e[15:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [39:0] e;
        int n;
        load(32'h12345678);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        mdl_a = '0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b y=%h want 0 0 0",
                     busy, done, y);
        end
        go(n);
        e = exp_q.pop_front();
        total++;
        if (n !== 8 || done !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset run: busy_cyc=%0d done=%b ovf=%b want 8 1 0",
                     n, done, ovf);
        end
        rd(1'b1, 1'b0);
        total++;
        if (y !== e[31:16]) begin
            bad++;
            $display("FAIL mid_reset msb: y=%h want %h", y, e[31:16]);
        end
        rd(1'b0, 1'b1);
        total++;
        if (y !== e[15:0]) begin
            bad++;
            $display("FAIL mid_reset lsb: y=%h want %h", y, e[15:0]);
        end
    endtask

    task automatic test_load_start();
        logic [39:0] e;
        int n;
        x = 16'h0005; ld_lsb = 1'b1; start = 1'b1;
        tick();
        ld_lsb = 1'b0; start = 1'b0;
        mdl_a = {mdl_a[31:16], 16'h0005};
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ld_start: done=%b busy=%b want 0 0", done, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ld_start idle: busy=%b want 0", busy);
        end
        go(n);
        e = exp_q.pop_front();
        rd(1'b0, 1'b1);
        total++;
        if (n !== 8 || y !== e[15:0]) begin
            bad++;
            $display("FAIL ld_start run: busy_cyc=%0d y=%h want 8 %h",
                     n, y, e[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_run_ignore();
        test_reset_mid_run();
        test_load_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
